cordic_atan2: RTL and testbench

CORDIC_ATAN2 -- requirements
Module: cordic_atan2

---
 rtl/cordic_pkg.sv | 36 +++
 rtl/cordic_atan2.sv | 138 +++++++++++++
 tb/tb_cordic_atan2.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared constants and types for the iterative CORDIC atan2/magnitude engine.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cordic_pkg;

    localparam int DATA_W = 24;                 // Q2.22 inputs, Q3.21 outputs
    localparam int INT_W  = 27;                 // Q5.22 internal x/y
    localparam int N_ITER = 22;
    localparam int CNT_W  = 5;

    // 1/K for 22 micro-rotations, unsigned Q0.18.
    localparam logic [17:0] K_INV = 18'h26DD4;

    // Q3.21 angle constants.
    localparam logic signed [DATA_W-1:0] PI      = 24'sh6487ED;
    localparam logic signed [DATA_W-1:0] HALF_PI = 24'sh3243F7;

    // round(atan(2^-i) * 2^21), Q3.21.
    localparam logic signed [DATA_W-1:0] ATAN [0:N_ITER-1] = '{
        24'sh1921FB, 24'sh0ED634, 24'sh07D6DD, 24'sh03FAB7,
        24'sh01FF56, 24'sh00FFEB, 24'sh007FFD, 24'sh004000,
        24'sh002000, 24'sh001000, 24'sh000800, 24'sh000400,
        24'sh000200, 24'sh000100, 24'sh000080, 24'sh000040,
        24'sh000020, 24'sh000010, 24'sh000008, 24'sh000004,
        24'sh000002, 24'sh000001
    };

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        ITER,
        SCALE,
        DONE
    } state_t;

endpackage

// File: rtl/cordic_atan2.sv
// Vectoring-mode CORDIC: atan2(y,x) in Q3.21 radians and gain-corrected magnitude.
// Latency: 25 enabled cycles from accepted start to the one-cycle done pulse.
// Backpressure: none; start is ignored unless IDLE, clk_en low freezes everything.
module cordic_atan2
    import cordic_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic              start,
    input  logic [DATA_W-1:0] x_in,
    input  logic [DATA_W-1:0] y_in,
    output logic              done,
    output logic [DATA_W-1:0] angle,
    output logic [DATA_W-1:0] mag,
    output logic              busy
);

    // Product of Q5.22 and Q0.18 is Q5.40; drop 19 bits to reach Q.21.
    localparam int          MAG_SHIFT = 19;
    localparam logic [44:0] MAG_RND   = 45'd1 << (MAG_SHIFT - 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N_ITER - 1);

    state_t                   state;
    state_t                   state_nxt;
    logic [CNT_W-1:0]         iter_cnt;
    logic signed [INT_W-1:0]  x_r;
    logic signed [INT_W-1:0]  y_r;
    logic signed [DATA_W-1:0] z_r;
    logic signed [INT_W-1:0]  x_shift;
    logic signed [INT_W-1:0]  y_shift;
    logic [INT_W-1:0]         x_mag;
    logic [44:0]              prod;
    logic [DATA_W-1:0]        mag_nxt;

    // State register; clk_en low holds the FSM where it is.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else if (clk_en) begin
            state <= state_nxt;
        end
    end

    // Next-state and status outputs decoded from the current state.
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = PRE;
            PRE: begin
                busy      = 1'b1;
                state_nxt = ITER;
            end
            ITER: begin
                busy = 1'b1;
                if (iter_cnt == LAST_ITER) state_nxt = SCALE;
            end
            SCALE: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shifted operands for the current micro-rotation and the scale multiply.
    always_comb begin
        x_shift = x_r >>> iter_cnt;
        y_shift = y_r >>> iter_cnt;
        // x is non-negative after the quadrant fold; clamp guards the unsigned multiply.
        x_mag   = x_r[INT_W-1] ? '0 : x_r;
        prod    = 45'(x_mag) * 45'(K_INV);
        mag_nxt = DATA_W'((prod + MAG_RND) >> MAG_SHIFT);
    end

    // Datapath: capture, quadrant fold, micro-rotations, then gain removal.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_r      <= '0;
            y_r      <= '0;
            z_r      <= '0;
            iter_cnt <= '0;
            angle    <= '0;
            mag      <= '0;
        end else if (clk_en) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        x_r      <= {{(INT_W-DATA_W){x_in[DATA_W-1]}}, x_in};
                        y_r      <= {{(INT_W-DATA_W){y_in[DATA_W-1]}}, y_in};
                        z_r      <= '0;
                        iter_cnt <= '0;
                    end
                end
                PRE: begin
                    // Fold left half-plane into the right so the iterations converge.
                    // y == 0 with x < 0 takes the +pi/2 branch, giving +pi rather than -pi.
                    if (x_r[INT_W-1] && !y_r[INT_W-1]) begin
                        x_r <= y_r;
                        y_r <= -x_r;
                        z_r <= HALF_PI;
                    end else if (x_r[INT_W-1]) begin
                        x_r <= -y_r;
                        y_r <= x_r;
                        z_r <= -HALF_PI;
                    end else begin
                        z_r <= '0;
                    end
                end
                ITER: begin
                    if (!y_r[INT_W-1]) begin
                        x_r <= x_r + y_shift;
                        y_r <= y_r - x_shift;
                        z_r <= z_r + ATAN[iter_cnt];
                    end else begin
                        x_r <= x_r - y_shift;
                        y_r <= y_r + x_shift;
                        z_r <= z_r - ATAN[iter_cnt];
                    end
                    iter_cnt <= (iter_cnt == LAST_ITER) ? '0 : iter_cnt + CNT_W'(1);
                end
                SCALE: begin
                    // A zero vector never moves, but z would still sum the table.
                    angle <= (x_r == '0 && y_r == '0) ? '0 : z_r;
                    mag   <= mag_nxt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_atan2.sv
// Self-checking bench for cordic_atan2: vector table, corner sequences, random vs real-math model.
// Latency: expects done 25 enabled cycles after the start edge.
// Backpressure: exercises clk_en stalls and ignored starts.
module tb_cordic_atan2;

    localparam real SCL  = 4194304.0;               // Q2.22 scale
    localparam real OSC  = 2097152.0;               // Q3.21 scale
    localparam real PI_R = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;
    logic        start;
    logic [23:0] x_in;
    logic [23:0] y_in;
    logic        done;
    logic [23:0] angle;
    logic [23:0] mag;
    logic        busy;

    int checks = 0;
    int errors = 0;

    cordic_atan2 dut (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .start  (start),
        .x_in   (x_in),
        .y_in   (y_in),
        .done   (done),
        .angle  (angle),
        .mag    (mag),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] x;
        logic [23:0] y;
        logic [23:0] ang;
        logic [23:0] mg;
        int          atol;
        int          mtol;
    } vec_t;

    function automatic real q22(input logic [23:0] v);
        return real'($signed(v)) / SCL;
    endfunction

    function automatic real ref_angle(input logic [23:0] xv, input logic [23:0] yv);
        if (xv == 24'd0 && yv == 24'd0) return 0.0;
        return $atan2(q22(yv), q22(xv)) * OSC;
    endfunction

    function automatic real ref_mag(input logic [23:0] xv, input logic [23:0] yv);
        return $sqrt(q22(xv) * q22(xv) + q22(yv) * q22(yv)) * OSC;
    endfunction

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_tol(input string name, input int act, input real ref_v,
                             input real tol, input bit wrap);
        real d;
        checks++;
        d = real'(act) - ref_v;
        if (wrap) begin
            if (d > PI_R * OSC) d = d - 2.0 * PI_R * OSC;
            else if (d < -PI_R * OSC) d = d + 2.0 * PI_R * OSC;
        end
        if (d < 0.0) d = -d;
        if (d > tol) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0.2f +/- %0.1f", name, act, ref_v, tol);
        end
    endtask

    task automatic do_op(input logic [23:0] xa, input logic [23:0] ya, output int lat,
                         output logic [23:0] ang, output logic [23:0] mg);
        @(negedge clk);
        x_in = xa; y_in = ya; start = 1'b1; clk_en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        ang = angle;
        mg  = mag;
    endtask

    task automatic check_op(input string name, input logic [23:0] xa, input logic [23:0] ya);
        int lat;
        logic [23:0] ang, mg;
        do_op(xa, ya, lat, ang, mg);
        check_int({name, "_lat"}, lat, 25);
        check_tol({name, "_ang"}, int'($signed(ang)), ref_angle(xa, ya), 4.0, 1'b1);
        check_tol({name, "_mag"}, int'(mg), ref_mag(xa, ya), 8.0, 1'b0);
    endtask

    // Cycle c = period after start edge c-1; inputs driven in cycle c are sampled at its end.
    task automatic run_seq(input logic [23:0] xa, input logic [23:0] ya, input int start2,
                           input int en_lo, input int en_len, input int rst_cyc, input int exp_done,
                           output int first_done, output int ndone, output int busy_bad,
                           output logic [23:0] ang, output logic [23:0] mg);
        first_done = -1; ndone = 0; busy_bad = 0; ang = '0; mg = '0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (first_done < 0) begin
                    first_done = c; ang = angle; mg = mag;
                end
            end
            if (exp_done > 0 && busy != (c >= 1 && c < exp_done)) busy_bad++;
            start  = (c == 0 || c == start2);
            x_in   = (c == 0) ? xa : ~xa;
            y_in   = (c == 0) ? ya : ~ya;
            clk_en = !(c >= en_lo && c < en_lo + en_len);
            reset  = (c == rst_cyc);
        end
        start = 1'b0; clk_en = 1'b1; reset = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        tbl [8];
        int          lat, fd, nd, bb;
        logic [23:0] ang, mg, xr, yr;
        real         r;
        int          tries;

        tbl[0] = '{24'h400000, 24'h000000, 24'h000000, 24'h200000, 4, 8};
        tbl[1] = '{24'h000000, 24'h400000, 24'h3243F7, 24'h200000, 4, 8};
        tbl[2] = '{24'h400000, 24'h400000, 24'h1921FB, 24'h2D413D, 4, 8};
        tbl[3] = '{24'hC00000, 24'h000000, 24'h6487ED, 24'h200000, 4, 8};
        tbl[4] = '{24'hC00000, 24'hFFFFFF, 24'h9B7813, 24'h200000, 4, 8};
        tbl[5] = '{24'h000000, 24'h000000, 24'h000000, 24'h000000, 0, 0};
        tbl[6] = '{24'h000000, 24'hC00000, 24'hCDBC09, 24'h200000, 4, 8};
        tbl[7] = '{24'hC00000, 24'h400000, 24'h4B65F2, 24'h2D413D, 4, 8};

        reset = 1'b1; clk_en = 1'b1; start = 1'b0; x_in = '0; y_in = '0;
        repeat (3) @(negedge clk);
        check_int("rst_done",  int'(done),  0);
        check_int("rst_busy",  int'(busy),  0);
        check_int("rst_angle", int'(angle), 0);
        check_int("rst_mag",   int'(mag),   0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_op(tbl[i].x, tbl[i].y, lat, ang, mg);
            check_int($sformatf("tbl%0d_lat", i), lat, 25);
            check_tol($sformatf("tbl%0d_ang", i), int'($signed(ang)),
                      real'($signed(tbl[i].ang)), real'(tbl[i].atol), 1'b0);
            check_tol($sformatf("tbl%0d_mag", i), int'(mg), real'(tbl[i].mg),
                      real'(tbl[i].mtol), 1'b0);
        end

        // Second start at cycle 5 must be ignored.
        run_seq(24'h400000, 24'h400000, 5, -1, 0, -1, 25, fd, nd, bb, ang, mg);
        check_int("dbl_start_first", fd, 25);
        check_int("dbl_start_count", nd, 1);
        check_int("dbl_start_busy_bad", bb, 0);
        check_tol("dbl_start_ang", int'($signed(ang)), real'(24'h1921FB), 4.0, 1'b0);
        check_tol("dbl_start_mag", int'(mg), real'(24'h2D413D), 8.0, 1'b0);

        // Seven stalled cycles mid-ITER push done from 25 to 32.
        run_seq(24'h2A0000, 24'hE30000, -1, 10, 7, -1, 32, fd, nd, bb, ang, mg);
        check_int("stall_first", fd, 32);
        check_int("stall_count", nd, 1);
        check_int("stall_busy_bad", bb, 0);
        check_tol("stall_ang", int'($signed(ang)), ref_angle(24'h2A0000, 24'hE30000), 4.0, 1'b1);
        check_tol("stall_mag", int'(mg), ref_mag(24'h2A0000, 24'hE30000), 8.0, 1'b0);

        // clk_en low for 3 cycles while in DONE stretches the pulse to 4 cycles.
        run_seq(24'hC00000, 24'h000000, -1, 25, 3, -1, 0, fd, nd, bb, ang, mg);
        check_int("hold_done_first", fd, 25);
        check_int("hold_done_count", nd, 4);
        check_tol("hold_done_ang", int'($signed(ang)), real'(24'h6487ED), 4.0, 1'b0);

        // Reset at cycle 10 aborts with no done and clears results.
        run_seq(24'h400000, 24'h400000, -1, -1, 0, 10, 0, fd, nd, bb, ang, mg);
        check_int("abort_done_count", nd, 0);
        check_int("abort_angle", int'(angle), 0);
        check_int("abort_mag", int'(mag), 0);
        check_int("abort_busy", int'(busy), 0);
        check_op("after_rst", 24'h300000, 24'hD00000);

        for (int n = 0; n < 40; n++) begin
            tries = 0;
            do begin
                xr = 24'($urandom_range(0, 32'hC00000)) - 24'h600000;
                yr = 24'($urandom_range(0, 32'hC00000)) - 24'h600000;
                r  = $sqrt(q22(xr) * q22(xr) + q22(yr) * q22(yr));
                tries++;
            end while ((r < 0.9 || r > 1.3) && tries < 1000);
            check_op($sformatf("rnd%0d", n), xr, yr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
